// File: rtl/gray_decoder_monitor_pkg.sv
// Shared types and helpers for the Gray-code receive monitor.
// The optional error counter is enabled by defining GRAY_DEC_ERRCNT_EN.
package gray_decoder_monitor_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mon_state_e;

  localparam int unsigned DEF_WIDTH     = 32'd4;
  localparam int unsigned DEF_ERR_CNT_W = 32'd8;

  // Zero-extended Gray words decode identically, so one 32-bit helper serves any width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decoder_monitor_gray2bin_comb.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder, MSB downward.
module gray2bin_comb
  import gray_decoder_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    logic [WIDTH-1:0] acc;
    acc            = '0;
    acc[WIDTH-1]   = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      acc[i] = acc[i+1] ^ gray_i[i];
    end
    bin_o = acc;
  end

endmodule

// File: rtl/gray_decoder_monitor.sv
// Two-stage Gray decoder with a repeat/+1 sequence monitor.
// Define GRAY_DEC_ERRCNT_EN to build the saturating err_count register.
module gray_decoder_monitor
  import gray_decoder_monitor_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 out_valid,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] g_q;
  logic             v_q;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] succ_s;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q, step_err_d;
  logic             locked_q, locked_d;
  mon_state_e       state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      g_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        g_q <= gray_in;
      end
    end
  end

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray_i (g_q),
    .bin_o  (dec_s)
  );

  // Adding one in WIDTH bits makes all-ones -> zero a legal step.
  assign succ_s = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    bin_d       = bin_q;
    prev_d      = prev_q;
    out_valid_d = 1'b0;
    step_err_d  = 1'b0;
    locked_d    = locked_q;
    state_d     = state_q;
    if (v_q) begin
      bin_d       = dec_s;
      prev_d      = dec_s;
      out_valid_d = 1'b1;
      case (state_q)
        UNLOCKED: begin
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
        LOCKED: begin
          if ((dec_s != prev_q) && (dec_s != succ_s)) begin
            step_err_d = 1'b1;
          end else begin
            step_err_d = 1'b0;
          end
        end
        default: begin
          locked_d = 1'b0;
          state_d  = UNLOCKED;
        end
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q       <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      state_q     <= UNLOCKED;
    end else begin
      bin_q       <= bin_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
      locked_q    <= locked_d;
      state_q     <= state_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign step_err  = step_err_q;
  assign locked    = locked_q;

`ifdef GRAY_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Counts alongside the step_err register so both update in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (step_err_d && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
